// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the accumulator CPU blocks.
//   - sequencer state encoding (IDLE/FETCH/EXEC/HALTED)
//   - sequencer mode encoding (STEP/RUN)
//   - opcode constants shared with the instruction decoder
//   - default widths for the program counter and retired-instruction counter
package cpu_pkg;

  localparam int PCBTS_DEF  = 11;
  localparam int CNTBTS_DEF = 16;

  // Sequencer states, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_FETCH  = 2'b01;
  localparam logic [1:0] ST_EXEC   = 2'b10;
  localparam logic [1:0] ST_HALTED = 2'b11;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  // Opcode field of the instruction word, decoded downstream.
  typedef enum logic [3:0] {
    OP_HLT  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_JMP  = 4'h5,
    OP_JZ   = 4'h6,
    OP_LDI  = 4'h7,
    OP_ADDI = 4'h8,
    OP_SUBI = 4'h9
  } opcode_e;

  // True for the opcode that stops the sequencer.
  function automatic logic is_halt_op(input logic [3:0] op);
    return (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   i_clk   - rising-edge clock
//   i_reset - asynchronous active-high reset (count -> 0)
//   i_clr   - synchronous clear, wins over i_en
//   i_en    - count enable, one increment per cycle
//   o_cnt   - registered count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = &r_cnt;

  // Count register: clear wins, otherwise increment until all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && !w_at_max) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute sequencer for the accumulator CPU.
// Owns the program counter and steps each instruction through FETCH
// (ROM read) and EXEC (decoder outputs applied). Free-running (RUN) or
// single-step (STEP) mode; HALT parks the machine until i_clear/i_reset.
// Ports:
//   i_clk, i_reset      - clock, asynchronous active-high reset
//   i_run, i_step       - start pulses, honoured only in IDLE (run wins)
//   i_clear             - synchronous return to IDLE, PC/counter zeroed
//   i_h_flg, i_w_pc     - decoder halt flag / PC write, used only in EXEC
//   o_pc                - registered ROM address
//   o_fetch, o_exec_en  - FETCH / EXEC phase strobes
//   o_busy, o_halted    - activity / halted status
//   o_inst_cnt          - retired (non-HALT) instruction count, saturating
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PCBTS  = PCBTS_DEF,
  parameter int CNTBTS = CNTBTS_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic              i_h_flg,
  input  logic              i_w_pc,
  output logic [PCBTS-1:0]  o_pc,
  output logic              o_fetch,
  output logic              o_exec_en,
  output logic              o_busy,
  output logic              o_halted,
  output logic [CNTBTS-1:0] o_inst_cnt
);

  logic [1:0]       r_state;
  logic             r_mode;
  logic [PCBTS-1:0] r_pc;

  logic [1:0]       w_state_nxt;
  logic             w_mode_nxt;
  logic [PCBTS-1:0] w_pc_nxt;
  logic             w_retire;

  // Next-state, mode and PC decode; i_clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_pc_nxt    = r_pc;
    w_retire    = 1'b0;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_mode_nxt  = MODE_STEP;
      w_pc_nxt    = {PCBTS{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            w_mode_nxt  = MODE_RUN;
            w_state_nxt = ST_FETCH;
          end else if (i_step) begin
            w_mode_nxt  = MODE_STEP;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FETCH: begin
          w_state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          if (i_h_flg) begin
            // HALT does not retire: PC and counter stay put.
            w_state_nxt = ST_HALTED;
          end else begin
            w_retire = 1'b1;
            if (i_w_pc) begin
              w_pc_nxt = r_pc + PCBTS'(1);  // wraps modulo 2^PCBTS
            end else begin
              w_pc_nxt = r_pc;
            end
            if (r_mode == MODE_RUN) begin
              w_state_nxt = ST_FETCH;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_HALTED: begin
          w_state_nxt = ST_HALTED;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, mode and program counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_STEP;
      r_pc    <= {PCBTS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  sat_counter #(
    .W (CNTBTS)
  ) u_inst_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear),
    .i_en    (w_retire),
    .o_cnt   (o_inst_cnt)
  );

  // Strobes decode straight from the state register, never from inputs.
  assign o_pc      = r_pc;
  assign o_fetch   = (r_state == ST_FETCH);
  assign o_exec_en = (r_state == ST_EXEC);
  assign o_busy    = (r_state == ST_FETCH) || (r_state == ST_EXEC);
  assign o_halted  = (r_state == ST_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a default-width instance (PCBTS=11, CNTBTS=16)
// and a narrow instance (PCBTS=2, CNTBTS=2) share one input stream. Each
// cycle the expected post-edge outputs are queued from a reference model
// and checked against both instances; directed checks cover the key
// timing points with hand-derived constants.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_reset, i_run, i_step, i_clear, i_h_flg, i_w_pc;

  logic [10:0] b_pc;
  logic [15:0] b_cnt;
  logic        b_fetch, b_exec, b_busy, b_halted;
  logic [1:0]  s_pc;
  logic [1:0]  s_cnt;
  logic        s_fetch, s_exec, s_busy, s_halted;

  cpu_sequencer #(.PCBTS(11), .CNTBTS(16)) u_big (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_clear(i_clear), .i_h_flg(i_h_flg), .i_w_pc(i_w_pc),
    .o_pc(b_pc), .o_fetch(b_fetch), .o_exec_en(b_exec), .o_busy(b_busy),
    .o_halted(b_halted), .o_inst_cnt(b_cnt)
  );

  cpu_sequencer #(.PCBTS(2), .CNTBTS(2)) u_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_clear(i_clear), .i_h_flg(i_h_flg), .i_w_pc(i_w_pc),
    .o_pc(s_pc), .o_fetch(s_fetch), .o_exec_en(s_exec), .o_busy(s_busy),
    .o_halted(s_halted), .o_inst_cnt(s_cnt)
  );

  typedef struct {
    logic [1:0] st;
    int         pc;
    int         cb;
    int         cs;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [1:0] m_st;
  logic       m_mode;
  int         m_pc, m_cb, m_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_mode = MODE_STEP; m_pc = 0; m_cb = 0; m_cs = 0;
  endtask

  task automatic model_step(input logic run, input logic step, input logic clr,
                            input logic h, input logic wpc);
    if (clr) begin
      m_st = ST_IDLE; m_mode = MODE_STEP; m_pc = 0; m_cb = 0; m_cs = 0;
    end else begin
      case (m_st)
        ST_IDLE: begin
          if (run) begin m_mode = MODE_RUN; m_st = ST_FETCH; end
          else if (step) begin m_mode = MODE_STEP; m_st = ST_FETCH; end
        end
        ST_FETCH: m_st = ST_EXEC;
        ST_EXEC: begin
          if (h) m_st = ST_HALTED;
          else begin
            if (wpc) m_pc = m_pc + 1;
            if (m_cb < 65535) m_cb = m_cb + 1;
            if (m_cs < 3) m_cs = m_cs + 1;
            m_st = (m_mode == MODE_RUN) ? ST_FETCH : ST_IDLE;
          end
        end
        default: m_st = ST_HALTED;
      endcase
    end
  endtask

  task automatic chk_outs(input exp_t e);
    chk("big.pc",     {21'd0, b_pc},  e.pc & 32'h7ff);
    chk("big.cnt",    {16'd0, b_cnt}, e.cb);
    chk("big.fetch",  {31'd0, b_fetch},  {31'd0, e.st == ST_FETCH});
    chk("big.exec",   {31'd0, b_exec},   {31'd0, e.st == ST_EXEC});
    chk("big.busy",   {31'd0, b_busy},   {31'd0, (e.st == ST_FETCH) || (e.st == ST_EXEC)});
    chk("big.halted", {31'd0, b_halted}, {31'd0, e.st == ST_HALTED});
    chk("small.pc",     {30'd0, s_pc},  e.pc & 32'h3);
    chk("small.cnt",    {30'd0, s_cnt}, e.cs);
    chk("small.fetch",  {31'd0, s_fetch},  {31'd0, e.st == ST_FETCH});
    chk("small.exec",   {31'd0, s_exec},   {31'd0, e.st == ST_EXEC});
    chk("small.busy",   {31'd0, s_busy},   {31'd0, (e.st == ST_FETCH) || (e.st == ST_EXEC)});
    chk("small.halted", {31'd0, s_halted}, {31'd0, e.st == ST_HALTED});
  endtask

  // One clock: drive inputs, queue the model's expectation, check after the edge.
  task automatic cyc(input logic run, input logic step, input logic clr,
                     input logic h, input logic wpc);
    exp_t e;
    i_run = run; i_step = step; i_clear = clr; i_h_flg = h; i_w_pc = wpc;
    model_step(run, step, clr, h, wpc);
    e.st = m_st; e.pc = m_pc; e.cb = m_cb; e.cs = m_cs;
    q.push_back(e);
    @(posedge i_clk);
    #1;
    if (q.size() == 0) begin
      chk("queue.empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk_outs(e);
    end
  endtask

  task automatic chk_all_reset();
    chk("rst.big.pc", {21'd0, b_pc}, 32'd0);
    chk("rst.big.cnt", {16'd0, b_cnt}, 32'd0);
    chk("rst.big.flags", {28'd0, b_fetch, b_exec, b_busy, b_halted}, 32'd0);
    chk("rst.small.pc", {30'd0, s_pc}, 32'd0);
    chk("rst.small.cnt", {30'd0, s_cnt}, 32'd0);
    chk("rst.small.flags", {28'd0, s_fetch, s_exec, s_busy, s_halted}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0; i_clear = 1'b0;
    i_h_flg = 1'b0; i_w_pc = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_reset();
    @(negedge i_clk);
    i_reset = 1'b0;

    // Single step with PC write.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("step.c1.fetch", {31'd0, b_fetch}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("step.c2.exec", {31'd0, b_exec}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("step.c3.busy", {31'd0, b_busy}, 32'd0);
    chk("step.pc", {21'd0, b_pc}, 32'd1);
    chk("step.cnt", {16'd0, b_cnt}, 32'd1);
    // Halt flag in IDLE has no effect.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle.hflg.halted", {31'd0, b_halted}, 32'd0);

    // Run with HALT on the 4th EXEC (cycle 8); a step pulse in FETCH is ignored.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, (k == 3), 1'b0, (k == 8), 1'b1);
    end
    chk("halt.c9.halted", {31'd0, b_halted}, 32'd1);
    chk("halt.pc", {21'd0, b_pc}, 32'd3);
    chk("halt.cnt", {16'd0, b_cnt}, 32'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("halt.hold.halted", {31'd0, b_halted}, 32'd1);
    chk("halt.hold.pc", {21'd0, b_pc}, 32'd3);

    // Clear from HALTED, then step from address 0.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr.pc", {21'd0, b_pc}, 32'd0);
    chk("clr.cnt", {16'd0, b_cnt}, 32'd0);
    chk("clr.halted", {31'd0, b_halted}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr.step.fetch_addr", {21'd0, b_pc}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr.step.pc", {21'd0, b_pc}, 32'd1);

    // Run 6 instructions: PC wrap on the narrow instance, count saturation.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("wrap.small.pc", {30'd0, s_pc}, i % 4);
      if (i == 5) begin
        chk("wrap.big.cnt5", {16'd0, b_cnt}, 32'd5);
        chk("sat.small.cnt5", {30'd0, s_cnt}, 32'd3);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("sat.big.cnt6", {16'd0, b_cnt}, 32'd6);
    chk("sat.small.cnt6", {30'd0, s_cnt}, 32'd3);

    // Simultaneous run and step: run wins, back-to-back instructions.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("both.runmode.fetch", {31'd0, b_fetch}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Async reset in the middle of EXEC aborts the instruction.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("arst.pre.exec", {31'd0, b_exec}, 32'd1);
    i_reset = 1'b1;
    #1;
    chk_all_reset();
    model_reset();
    @(posedge i_clk);
    #1;
    chk_all_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("arst.post.pc", {21'd0, b_pc}, 32'd1);
    chk("arst.post.cnt", {16'd0, b_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
